stump_mem_interface: RTL
========================

// Module: stump_mem_interface
// PURPOSE
//  Memory-stage bus bridge for the Stump processor. Sits downstream of the
//  control decoder: converts the one-cycle-level mem_ren/mem_wen strobes into a
//  req/ack handshake on a variable-latency memory bus.
//  Holds the control FSM via stall until the access completes, then presents
//  read data to the register writeback path.
// PARAMETERS
//  AW       16  address width (bits)
//  DW       16  data width (bits)
//  TIMEOUT  15  max REQ cycles before abort (STUMP_MEM_TIMEOUT_EN only), >=1
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mem_ren    in   1   read request from control
//  mem_wen    in   1   write request from control
//  addr       in   AW  access address (ALU result)
//  wdata      in   DW  store data (register srcA)
//  rdata      out  DW  registered load data, to writeback mux
//  stall      out  1   freeze control FSM/PC while high
//  bus_req    out  1   bus request, registered
//  bus_we     out  1   1 = write, 0 = read, registered
//  bus_addr   out  AW  registered address
//  bus_wdata  out  DW  registered write data
//  bus_ack    in   1   bus completion, sampled only in REQ
//  bus_rdata  in   DW  read data, valid with bus_ack
//  bus_err    out  1   one-cycle abort flag (0 when timeout disabled)
// BEHAVIOUR
//  - Reset (async): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0,
//    rdata=0, bus_err=0, timeout count=0. stall=0 while rst high.
//  - States: IDLE -> REQ -> DONE -> IDLE.
//  - IDLE: if mem_ren|mem_wen: latch addr->bus_addr, wdata->bus_wdata,
//    bus_we=mem_wen, bus_req<=1, go REQ. Both high: write wins (bus_we=1).
//  - REQ: bus_req held 1, bus_addr/we/wdata stable. On bus_ack: bus_req<=0;
//    if read, rdata<=bus_rdata; go DONE. Writes leave rdata unchanged.
//  - DONE: stall=0 for exactly one cycle so control leaves MEMORY; unconditional
//    return to IDLE. Requests still asserted in DONE are ignored (no re-issue).
//  - stall = (IDLE & (mem_ren|mem_wen)) | REQ. Combinational, same cycle.
//  - Latency: request cycle C, earliest ack at C+1, DONE at C+2. Total
//    minimum 3 cycles; each wait-state cycle of ack delay adds one.
//  - bus_ack outside REQ: ignored, no state change.
//  - Reset mid-access: bus_req drops asynchronously. Access abandoned, no
//    retry. rdata=0.
// CONFIGURATION
//  - STUMP_MEM_TIMEOUT_EN defined: counter clears on IDLE->REQ, increments
//    each REQ cycle without ack. Reaching TIMEOUT aborts the access:
//    bus_req<=0, rdata<=0 (reads), bus_err=1 for the DONE cycle only, go DONE.
//    Ack and timeout in the same cycle: ack wins, bus_err=0.
//  - Undefined: no counter. REQ waits indefinitely for ack. bus_err tied 0.
// TESTING
//  - rst high mid-run -> all outputs 0, state IDLE. Release; idle 5 cycles
//    -> bus_req stays 0.
//  - Read addr=16'h0040, ack 1 cycle after req with bus_rdata=16'hBEEF
//    -> stall high 2 cycles, then 0 for 1. rdata=16'hBEEF in the DONE cycle.
//  - Write addr=16'h0010, wdata=16'h1234, ack after 3 wait states
//    -> bus_we=1, bus_wdata=16'h1234 stable for 4 REQ cycles. rdata unchanged.
//  - mem_ren=mem_wen=1 -> bus_we=1 (write issued). Stray ack in IDLE -> ignored.
//  - TIMEOUT_EN, TIMEOUT=4, no ack -> abort after 4 REQ cycles, bus_err one-cycle
//    pulse, rdata=0, stall drops.
//  - Assert rst in REQ cycle 2 -> bus_req=0 immediately. After release,
//    new read completes normally.

Source files
------------

// File: rtl/stump_mem_interface.sv
// -----------------------------------------------------------------------------
// stump_mem_interface
//   Memory-stage bus bridge for the Stump processor. Turns the level
//   mem_ren/mem_wen strobes from the control decoder into a req/ack handshake
//   on a variable-latency memory bus. The control FSM is frozen through
//   o_stall until the access completes. Load data is then held in o_rdata
//   for the register writeback path.
//
//   Access sequence: IDLE -> REQ -> DONE -> IDLE. DONE is a single cycle with
//   stall low, so control can leave its MEMORY state.
//
// Optional feature (macro STUMP_MEM_TIMEOUT_EN):
//   When defined, the parameter TIMEOUT (>= 1) is added. A REQ phase that sees
//   no ack for TIMEOUT cycles is aborted. In that case o_rdata is cleared for
//   reads, and o_bus_err pulses high for the DONE cycle.
//   When undefined, REQ waits indefinitely for an ack and o_bus_err is tied 0.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   i_mem_ren    in   read request from control
//   i_mem_wen    in   write request from control (wins if both are high)
//   i_addr       in   access address (ALU result), AW bits
//   i_wdata      in   store data, DW bits
//   o_rdata      out  registered load data, DW bits
//   o_stall      out  freeze control FSM/PC (combinational)
//   o_bus_req    out  bus request, registered
//   o_bus_we     out  1 = write, 0 = read, registered
//   o_bus_addr   out  registered bus address
//   o_bus_wdata  out  registered bus write data
//   i_bus_ack    in   bus completion, only looked at in REQ
//   i_bus_rdata  in   read data, valid with i_bus_ack
//   o_bus_err    out  one-cycle abort flag
// -----------------------------------------------------------------------------
module stump_mem_interface #(
    parameter int AW = 16,
    parameter int DW = 16
`ifdef STUMP_MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_mem_ren,
    input  logic          i_mem_wen,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic          o_stall,
    output logic          o_bus_req,
    output logic          o_bus_we,
    output logic [AW-1:0] o_bus_addr,
    output logic [DW-1:0] o_bus_wdata,
    input  logic          i_bus_ack,
    input  logic [DW-1:0] i_bus_rdata,
    output logic          o_bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_mem_req;
    logic          w_issue;
    logic          w_complete;
    logic          w_abort;
    logic          w_timeout;
    logic          w_stall;

    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic [DW-1:0] r_rdata;

    assign w_mem_req = i_mem_ren | i_mem_wen;

`ifdef STUMP_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_bus_err;

    // The count holds the number of REQ cycles already spent without an ack.
    // It therefore reaches TIMEOUT-1 in the last permitted cycle.
    assign w_timeout = (r_state == ST_REQ) && (r_to_cnt == CW'(TIMEOUT - 1));

    // Timeout counter: cleared on issue, advanced on every un-acked REQ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= {CW{1'b0}};
        end else if (w_issue) begin
            r_to_cnt <= {CW{1'b0}};
        end else if ((r_state == ST_REQ) && !i_bus_ack && !w_timeout) begin
            r_to_cnt <= r_to_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // The error flag is set on the abort edge, so it is high exactly for DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
        end
    end

    assign o_bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and per-cycle action decode.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_req) begin
                    w_issue      = 1'b1;
                    w_stall      = 1'b1;
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                // An ack takes priority over a timeout in the same cycle.
                if (i_bus_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DONE: begin
                // Requests still held by control here are ignored, so the
                // access is not issued a second time.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus-side registers: latched on issue, released on completion or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= {AW{1'b0}};
            r_bus_wdata <= {DW{1'b0}};
            r_rdata     <= {DW{1'b0}};
        end else if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= i_mem_wen;
            r_bus_addr  <= i_addr;
            r_bus_wdata <= i_wdata;
        end else if (w_complete) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
                r_rdata <= i_bus_rdata;
            end
        end else if (w_abort) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
                r_rdata <= {DW{1'b0}};
            end
        end
    end

    // Stall is forced low while reset is held, even if control is requesting.
    assign o_stall     = w_stall & ~rst;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_rdata     = r_rdata;

endmodule
